// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches one instruction word over a req/ack handshake,
// holds it for decode/execute and advances the PC when execute retires it.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   Stall,
  output logic                   IMemReq,
  output logic [31:0]            IMemAddr,
  input  logic                   IMemAck,
  input  logic [31:0]            IMemData,
  output logic                   InstrValid,
  output logic [31:0]            Instruction,
  output logic [5:0]             Opcode,
  output logic [31:0]            PC,
  output logic [31:0]            PCPlus4,
  input  logic                   Retire,
  input  logic                   Branch,
  input  logic                   Zero,
  input  logic                   Jump,
  output logic [COUNT_WIDTH-1:0] RetireCount
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state;
  logic [31:0] jumptarget;
  logic [31:0] branchoffset;
  logic [31:0] nextpc;

  assign PCPlus4      = PC + 32'd4;
  assign jumptarget   = {PCPlus4[31:28], Instruction[25:0], 2'b00};
  assign branchoffset = {{14{Instruction[15]}}, Instruction[15:0], 2'b00};

  // Every candidate target is word aligned, so PC[1:0] can never become nonzero.
  always_comb begin
    nextpc = PCPlus4;
    if (Jump)
      nextpc = jumptarget;
    else if (Branch && Zero)
      nextpc = PCPlus4 + branchoffset;
  end

  assign IMemReq    = (state == S_REQ);
  assign IMemAddr   = PC;
  assign InstrValid = (state == S_HOLD);
  assign Opcode     = Instruction[31:26];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= S_IDLE;
      PC          <= RESET_PC_ALIGNED;
      Instruction <= '0;
      RetireCount <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!Stall)
            state <= S_REQ;
        end
        // An issued request always runs to its ack; Stall only gates new requests.
        S_REQ: begin
          if (IMemAck) begin
            Instruction <= IMemData;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (Retire) begin
            PC          <= nextpc;
            RetireCount <= RetireCount + COUNT_WIDTH'(1);
            state       <= Stall ? S_IDLE : S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
